// File: rtl/it_prog_loader_pkg.sv
// Shared constants, state encodings and the state-to-output decode for the
// program-load sequencer.
package it_prog_loader_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_AW    = 5;
    localparam int DEF_DEPTH = 32;
    localparam int LEN_W     = 6;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEF_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_BYTE = 4'd1,
        S_SET_ADDR  = 4'd2,
        S_WRITE     = 4'd3,
        S_RD_ADDR   = 4'd4,
        S_RD_SAMPLE = 4'd5,
        S_CHECK     = 4'd6,
        S_RUN       = 4'd7,
        S_FAIL      = 4'd8
    } state_t;

    typedef struct packed {
        logic program_en;
        logic busy;
        logic cpu_reset;
        logic done;
        logic error;
        logic in_ready;
        logic addr_load;
        logic pr_load;
    } flags_t;

    // Moore decode; registered alongside the state so every flag is a flop output.
    function automatic flags_t state_flags(input state_t s);
        flags_t f;
        f            = '0;
        f.program_en = (s >= S_WAIT_BYTE) && (s <= S_CHECK);
        f.busy       = f.program_en;
        f.cpu_reset  = (s != S_RUN);
        f.done       = (s == S_RUN);
        f.error      = (s == S_FAIL);
        f.in_ready   = (s == S_WAIT_BYTE);
        f.addr_load  = (s == S_SET_ADDR) || (s == S_RD_ADDR);
        f.pr_load    = (s == S_WRITE);
        return f;
    endfunction

endpackage

// File: rtl/it_prog_loader.sv
// Program-load sequencer: streams bytes into the CPU program RAM, reads them
// back against a mod-256 checksum, and releases CpuReset only on a match.
//
// state       | meaning
// IDLE        | waiting for Start after reset
// WAIT_BYTE   | InReady high, waiting for a stream byte
// SET_ADDR    | load write address into datapath address register
// WRITE       | write latched byte into RAM
// RD_ADDR     | load read-back address
// RD_SAMPLE   | accumulate RAMout into the verify sum
// CHECK       | compare verify sum with stream checksum
// RUN         | verified, CPU released
// FAIL        | bad length or checksum mismatch, CPU held
module it_prog_loader
    import it_prog_loader_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [LEN_W-1:0] Length,
    input  logic             InValid,
    input  logic [DW-1:0]    InData,
    output logic             InReady,
    input  logic [DW-1:0]    RAMout,
    output logic             programEn,
    output logic [AW-1:0]    AddrSel,
    output logic             Addrload,
    output logic             PRload,
    output logic [DW-1:0]    ProgData,
    output logic             CpuReset,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic [DW-1:0]    Checksum,
    output logic [3:0]       outState
);

    state_t           state;
    flags_t           flg;
    logic [AW-1:0]    index;
    logic [LEN_W-1:0] len;
    logic [DW-1:0]    vsum;
    logic             more;
    logic             start_ok;

    assign more     = (LEN_W'(index) + LEN_W'(1)) < len;
    assign start_ok = (Length != '0) && (Length <= LEN_W'(DEPTH));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            flg      <= state_flags(S_IDLE);
            index    <= '0;
            len      <= '0;
            vsum     <= '0;
            Checksum <= '0;
            ProgData <= '0;
            AddrSel  <= '0;
        end else begin
            AddrSel <= '0;
            case (state)
                S_IDLE, S_RUN, S_FAIL: begin
                    if (Start && start_ok) begin
                        index    <= '0;
                        Checksum <= '0;
                        len      <= Length;
                        state    <= S_WAIT_BYTE;
                        flg      <= state_flags(S_WAIT_BYTE);
                    end else if (Start) begin
                        state <= S_FAIL;
                        flg   <= state_flags(S_FAIL);
                    end
                end
                S_WAIT_BYTE: begin
                    if (InValid && flg.in_ready) begin
                        ProgData <= InData;
                        Checksum <= Checksum + InData;
                        AddrSel  <= index;
                        state    <= S_SET_ADDR;
                        flg      <= state_flags(S_SET_ADDR);
                    end
                end
                S_SET_ADDR: begin
                    state <= S_WRITE;
                    flg   <= state_flags(S_WRITE);
                end
                S_WRITE: begin
                    if (more) begin
                        index <= index + AW'(1);
                        state <= S_WAIT_BYTE;
                        flg   <= state_flags(S_WAIT_BYTE);
                    end else begin
                        // AddrSel default of zero is the first read-back address.
                        index <= '0;
                        vsum  <= '0;
                        state <= S_RD_ADDR;
                        flg   <= state_flags(S_RD_ADDR);
                    end
                end
                S_RD_ADDR: begin
                    state <= S_RD_SAMPLE;
                    flg   <= state_flags(S_RD_SAMPLE);
                end
                S_RD_SAMPLE: begin
                    vsum <= vsum + RAMout;
                    if (more) begin
                        index   <= index + AW'(1);
                        AddrSel <= index + AW'(1);
                        state   <= S_RD_ADDR;
                        flg     <= state_flags(S_RD_ADDR);
                    end else begin
                        state <= S_CHECK;
                        flg   <= state_flags(S_CHECK);
                    end
                end
                S_CHECK: begin
                    if (vsum == Checksum) begin
                        state <= S_RUN;
                        flg   <= state_flags(S_RUN);
                    end else begin
                        state <= S_FAIL;
                        flg   <= state_flags(S_FAIL);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    flg   <= state_flags(S_IDLE);
                end
            endcase
        end
    end

    assign outState  = state;
    assign programEn = flg.program_en;
    assign Busy      = flg.busy;
    assign CpuReset  = flg.cpu_reset;
    assign Done      = flg.done;
    assign Error     = flg.error;
    assign InReady   = flg.in_ready;
    assign Addrload  = flg.addr_load;
    assign PRload    = flg.pr_load;

endmodule

// File: tb/tb_it_prog_loader.sv
// Bench for it_prog_loader: models the datapath RAM and address register and
// predicts timing, write order, checksum and pass/fail from the load rules.
module tb_it_prog_loader;
    import it_prog_loader_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset, Start, InValid;
    logic [5:0] Length;
    logic [7:0] InData, RAMout, ProgData, Checksum;
    logic [4:0] AddrSel;
    logic [3:0] outState;
    logic       InReady, programEn, Addrload, PRload, CpuReset, Busy, Done, Error;

    it_prog_loader dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Length(Length),
        .InValid(InValid), .InData(InData), .InReady(InReady), .RAMout(RAMout),
        .programEn(programEn), .AddrSel(AddrSel), .Addrload(Addrload), .PRload(PRload),
        .ProgData(ProgData), .CpuReset(CpuReset), .Busy(Busy), .Done(Done),
        .Error(Error), .Checksum(Checksum), .outState(outState)
    );

    always #5 Clock = ~Clock;

    // Datapath model: address register, 32-byte RAM, optional read corruption.
    logic [7:0] ram [0:31];
    logic [4:0] addr_reg;
    logic       corrupt_en = 1'b0;
    logic [4:0] corrupt_addr = '0;
    logic [7:0] corrupt_val = '0;
    assign RAMout = (corrupt_en && addr_reg == corrupt_addr) ? corrupt_val : ram[addr_reg];

    always @(posedge Clock) begin
        if (Addrload) addr_reg <= AddrSel;
        if (PRload) ram[addr_reg] <= ProgData;
    end

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int sc = 0;
    logic [4:0] wr_addr [$];
    logic [7:0] wr_data [$];
    int         wr_cyc  [$];
    int         al_cnt = 0;
    int         excl_cnt = 0;

    always @(negedge Clock) begin
        if (PRload) begin
            wr_addr.push_back(addr_reg);
            wr_data.push_back(ProgData);
            wr_cyc.push_back(cyc - sc);
        end
        if (Addrload) al_cnt <= al_cnt + 1;
        if (int'(Addrload) + int'(PRload) + int'(InReady) > 1) excl_cnt <= excl_cnt + 1;
    end

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] bytes [0:31];
    int   done_rel, err_rel, stalls;
    logic pre_cpurst, first_done, first_cpurst;
    logic [3:0] first_state;

    // Pulses Start, then streams bytes[0..len_in-1] with `gap` stall cycles
    // before each byte, optionally re-pulsing Start at relative cycle poke_rel.
    task automatic drive_load(input int len_in, input int gap, input int poke_rel,
                              input logic [5:0] poke_len, input int maxc);
        int k, gapc, rel;
        k = 0; gapc = gap; done_rel = -1; err_rel = -1; stalls = 0;
        pre_cpurst = 1'b0; first_done = 1'b0; first_cpurst = 1'b0; first_state = '0;
        @(negedge Clock);
        Start = 1'b1; Length = 6'(len_in); InValid = 1'b0; sc = cyc;
        for (int c = 0; c < maxc; c++) begin
            @(negedge Clock);
            rel = cyc - sc;
            Start = (rel == poke_rel);
            if (rel == poke_rel) Length = poke_len;
            if (rel == 1) begin
                first_done = Done; first_cpurst = CpuReset; first_state = outState;
            end
            if (Done) begin done_rel = rel; break; end
            if (Error) begin err_rel = rel; break; end
            pre_cpurst = CpuReset;
            if (k < len_in && gapc == 0) begin
                InValid = 1'b1; InData = bytes[k];
            end else begin
                InValid = 1'b0; InData = 8'($urandom);
            end
            if (InReady) begin
                if (InValid) begin k++; gapc = gap; end
                else begin stalls++; if (gapc > 0) gapc--; end
            end
        end
        Start = 1'b0; InValid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Length = '0; InValid = 1'b0; InData = '0;
        repeat (3) @(negedge Clock);
        n_cmp++; if (outState !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", outState); end
        n_cmp++; if (CpuReset !== 1'b1) begin n_fail++; $display("FAIL reset_cpureset: got %b want 1", CpuReset); end
        n_cmp++; if ({programEn, Busy, Done, Error, InReady, Addrload, PRload} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000000", {programEn, Busy, Done, Error, InReady, Addrload, PRload}); end
        n_cmp++; if ({Checksum, ProgData, AddrSel} !== 21'b0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {Checksum, ProgData, AddrSel}); end
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        n_cmp++; if (outState !== 4'd0 || CpuReset !== 1'b1) begin
            n_fail++; $display("FAIL idle_hold: got state %0d cpurst %b want 0 1", outState, CpuReset); end
    endtask

    task automatic test_len3();
        int base, a0, e0;
        bytes[0] = 8'h10; bytes[1] = 8'h20; bytes[2] = 8'h30;
        corrupt_en = 1'b0; base = wr_addr.size(); a0 = al_cnt; e0 = excl_cnt;
        drive_load(3, 0, -1, 6'd0, 200);
        n_cmp++; if (wr_addr.size() - base !== 3) begin n_fail++; $display("FAIL len3_writes: got %0d want 3", wr_addr.size() - base); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (wr_cyc[base+i] !== 3 * (i + 1) || wr_data[base+i] !== bytes[i] || wr_addr[base+i] !== 5'(i)) begin
                n_fail++; $display("FAIL len3_write%0d: got cyc %0d data %h addr %0d want cyc %0d data %h addr %0d",
                    i, wr_cyc[base+i], wr_data[base+i], wr_addr[base+i], 3 * (i + 1), bytes[i], i); end
        end
        n_cmp++; if (Checksum !== 8'h60) begin n_fail++; $display("FAIL len3_checksum: got %h want 60", Checksum); end
        n_cmp++; if (done_rel !== 17) begin n_fail++; $display("FAIL len3_done_cycle: got %0d want 17", done_rel); end
        n_cmp++; if (CpuReset !== 1'b0 || pre_cpurst !== 1'b1) begin
            n_fail++; $display("FAIL len3_cpureset: got at_done %b before %b want 0 1", CpuReset, pre_cpurst); end
        n_cmp++; if (al_cnt - a0 !== 6 || excl_cnt !== e0) begin
            n_fail++; $display("FAIL len3_strobes: got addrloads %0d overlaps %0d want 6 0", al_cnt - a0, excl_cnt - e0); end
    endtask

    task automatic test_corrupt();
        bytes[0] = 8'hFF; bytes[1] = 8'h02;
        corrupt_en = 1'b1; corrupt_addr = 5'd1; corrupt_val = 8'h03;
        drive_load(2, 0, -1, 6'd0, 200);
        corrupt_en = 1'b0;
        n_cmp++; if (err_rel !== 12 || done_rel !== -1) begin
            n_fail++; $display("FAIL corrupt_outcome: got err %0d done %0d want err 12 done -1", err_rel, done_rel); end
        n_cmp++; if (Checksum !== 8'h01) begin n_fail++; $display("FAIL corrupt_checksum: got %h want 01", Checksum); end
        n_cmp++; if (CpuReset !== 1'b1 || Error !== 1'b1 || outState !== 4'd8) begin
            n_fail++; $display("FAIL corrupt_state: got cpurst %b err %b state %0d want 1 1 8", CpuReset, Error, outState); end
    endtask

    task automatic test_bad_len();
        logic [5:0] lens [3];
        int a0, p0;
        lens[0] = 6'd0; lens[1] = 6'd33; lens[2] = 6'($urandom_range(34, 63));
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock); Reset = 1'b1;
            @(negedge Clock); Reset = 1'b0;
            a0 = al_cnt; p0 = wr_addr.size();
            @(negedge Clock); Start = 1'b1; Length = lens[i];
            @(negedge Clock); Start = 1'b0;
            n_cmp++; if (outState !== 4'd8 || Error !== 1'b1 || Busy !== 1'b0 || CpuReset !== 1'b1) begin
                n_fail++; $display("FAIL badlen_%0d: got state %0d err %b busy %b cpurst %b want 8 1 0 1",
                    lens[i], outState, Error, Busy, CpuReset); end
            @(negedge Clock);
            n_cmp++; if (al_cnt !== a0 || wr_addr.size() !== p0) begin
                n_fail++; $display("FAIL badlen_%0d_strobes: got addrloads %0d writes %0d want 0 0",
                    lens[i], al_cnt - a0, wr_addr.size() - p0); end
        end
    endtask

    task automatic test_gaps();
        int n, base, bad;
        logic [7:0] sum;
        n = $urandom_range(3, 8); sum = '0; base = wr_addr.size(); bad = 0;
        for (int i = 0; i < n; i++) begin bytes[i] = 8'($urandom); sum = sum + bytes[i]; end
        drive_load(n, 4, -1, 6'd0, 2000);
        for (int i = 0; i < n; i++)
            if (wr_addr[base+i] !== 5'(i) || wr_data[base+i] !== bytes[i]) bad++;
        n_cmp++; if (wr_addr.size() - base !== n || bad !== 0) begin
            n_fail++; $display("FAIL gaps_writes: got %0d writes %0d bad want %0d writes 0 bad", wr_addr.size() - base, bad, n); end
        n_cmp++; if (stalls !== 4 * n) begin n_fail++; $display("FAIL gaps_inready_held: got %0d want %0d", stalls, 4 * n); end
        n_cmp++; if (done_rel !== 9 * n + 2 || Checksum !== sum) begin
            n_fail++; $display("FAIL gaps_done: got cyc %0d sum %h want cyc %0d sum %h", done_rel, Checksum, 9 * n + 2, sum); end
    endtask

    task automatic test_start_ignored();
        int n, base, poke;
        logic [7:0] sum;
        n = 6; sum = '0; base = wr_addr.size();
        for (int i = 0; i < n; i++) begin bytes[i] = 8'($urandom); sum = sum + bytes[i]; end
        poke = $urandom_range(1, 7 * n + 1);
        drive_load(n, 2, poke, 6'($urandom_range(1, 5)), 2000);
        n_cmp++; if (done_rel !== 7 * n + 2 || wr_addr.size() - base !== n || Checksum !== sum) begin
            n_fail++; $display("FAIL start_ignored_at_%0d: got cyc %0d writes %0d sum %h want %0d %0d %h",
                poke, done_rel, wr_addr.size() - base, Checksum, 7 * n + 2, n, sum); end
    endtask

    task automatic test_restart_run();
        int n;
        n = $urandom_range(1, 4);
        n_cmp++; if (Done !== 1'b1) begin n_fail++; $display("FAIL restart_precond: got done %b want 1", Done); end
        for (int i = 0; i < n; i++) bytes[i] = 8'($urandom);
        drive_load(n, 0, -1, 6'd0, 500);
        n_cmp++; if (first_done !== 1'b0 || first_cpurst !== 1'b1 || first_state !== 4'd1) begin
            n_fail++; $display("FAIL restart_first_cycle: got done %b cpurst %b state %0d want 0 1 1",
                first_done, first_cpurst, first_state); end
        n_cmp++; if (done_rel !== 5 * n + 2) begin n_fail++; $display("FAIL restart_done: got %0d want %0d", done_rel, 5 * n + 2); end
    endtask

    task automatic test_random();
        int n, gap, base, bad, exp_cyc;
        logic [7:0] sum, rsum;
        logic       bad_ram, exp_pass;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 32); gap = $urandom_range(0, 2);
            sum = '0; base = wr_addr.size(); bad = 0;
            for (int i = 0; i < n; i++) begin bytes[i] = 8'($urandom); sum = sum + bytes[i]; end
            bad_ram = 1'($urandom);
            corrupt_en = bad_ram; corrupt_addr = 5'($urandom_range(0, n - 1));
            corrupt_val = bytes[corrupt_addr] ^ 8'($urandom_range(1, 255));
            rsum = '0;
            for (int i = 0; i < n; i++) rsum = rsum + ((bad_ram && i == int'(corrupt_addr)) ? corrupt_val : bytes[i]);
            exp_pass = (rsum == sum);
            exp_cyc = 5 * n + 2 + gap * n;
            drive_load(n, gap, -1, 6'd0, 4000);
            corrupt_en = 1'b0;
            for (int i = 0; i < n; i++)
                if (wr_addr[base+i] !== 5'(i) || wr_data[base+i] !== bytes[i]) bad++;
            n_cmp++; if (wr_addr.size() - base !== n || bad !== 0 || Checksum !== sum) begin
                n_fail++; $display("FAIL rand%0d_load: got %0d writes %0d bad sum %h want %0d 0 %h",
                    it, wr_addr.size() - base, bad, Checksum, n, sum); end
            n_cmp++; if ((exp_pass ? done_rel : err_rel) !== exp_cyc || (exp_pass ? err_rel : done_rel) !== -1) begin
                n_fail++; $display("FAIL rand%0d_outcome: got done %0d err %0d want pass %b at %0d",
                    it, done_rel, err_rel, exp_pass, exp_cyc); end
        end
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) bytes[i] = 8'($urandom);
        @(negedge Clock); Start = 1'b1; Length = 6'd5; InValid = 1'b1; InData = bytes[0];
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock); Start = 1'b0;
            if (PRload) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL midwrite_reach: got no WRITE want WRITE within 20 cycles"); end
        #1 Reset = 1'b1; InValid = 1'b0;
        #1;
        n_cmp++; if (outState !== 4'd0 || CpuReset !== 1'b1 || PRload !== 1'b0 || InReady !== 1'b0) begin
            n_fail++; $display("FAIL midwrite_async: got state %0d cpurst %b prload %b inready %b want 0 1 0 0",
                outState, CpuReset, PRload, InReady); end
        @(negedge Clock);
        n_cmp++; if (outState !== 4'd0 || CpuReset !== 1'b1 || Busy !== 1'b0 || programEn !== 1'b0) begin
            n_fail++; $display("FAIL midwrite_next: got state %0d cpurst %b busy %b progen %b want 0 1 0 0",
                outState, CpuReset, Busy, programEn); end
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    initial begin
        test_reset();
        test_len3();
        test_corrupt();
        test_bad_len();
        test_gaps();
        test_start_ignored();
        test_restart_run();
        test_random();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule
